pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline-stage register that replaces the fixed-field, bubble-on-not-ready stage latches between the IF/ID/EXE/MEM/WB stages. The stage carries an opaque payload bus of any width under a valid/ready (allowin) handshake. It offers an optional skid entry for full throughput with a registered `in_ready`, a synchronous flush for branch/exception squash, optional zeroing of bubbles, and a saturating stall counter for performance analysis.

---
 rtl/pipe_stage_reg.sv | 151 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register: opaque payload, optional skid entry with registered
// in_ready, synchronous flush, optional bubble zeroing and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W          = 32,
  parameter int SKID            = 0,
  parameter int CLEAR_ON_BUBBLE = 1,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic              SKID_EN = (SKID != 0);
  localparam logic              CLR_EN  = (CLEAR_ON_BUBBLE != 0);
  localparam logic [DATA_W-1:0] ZERO    = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  state_t             state_r, state_s;
  logic [DATA_W-1:0]  main_r, main_s;
  logic [DATA_W-1:0]  skid_r, skid_s;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               in_fire_s;
  logic               out_fire_s;

  assign out_valid  = (state_r != ST_EMPTY);
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;
  // With bubble clearing, main is zeroed whenever the stage empties, so it can drive out_data directly.
  assign out_data   = main_r;
  assign stall_cnt  = stall_cnt_r;

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_r;

      // Registered allowin: the stage can accept unless the next state is FULL.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          in_ready_r <= 1'b1;
        end else begin
          in_ready_r <= (state_s != ST_FULL);
        end
      end

      assign in_ready = in_ready_r;
    end else begin : g_noskid
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  // Next-state and payload routing; flush overrides every transition.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush) begin
      state_s = ST_EMPTY;
      if (CLR_EN) begin
        main_s = ZERO;
        skid_s = ZERO;
      end else begin
        main_s = main_r;
        skid_s = skid_r;
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_s = ST_ONE;
            main_s  = in_data;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && (!SKID_EN || out_fire_s)) begin
            state_s = ST_ONE;
            main_s  = in_data;
          end else if (in_fire_s) begin
            state_s = ST_FULL;
            skid_s  = in_data;
          end else if (out_fire_s) begin
            state_s = ST_EMPTY;
            if (CLR_EN) begin
              main_s = ZERO;
            end else begin
              main_s = main_r;
            end
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_s = ST_ONE;
            main_s  = skid_r;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
          main_s  = ZERO;
          skid_s  = ZERO;
        end
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_EMPTY;
      main_r  <= ZERO;
      skid_r  <= ZERO;
    end else begin
      state_r <= state_s;
      main_r  <= main_s;
      skid_r  <= skid_s;
    end
  end

  // Saturating back-pressure counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stat_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid && !out_ready && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: three instances (no skid, skid, no bubble clearing
// with a 2-bit counter) driven by directed vectors; monitors pop expected payloads on out_fire.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       v0, r0, f0, c0, ir0, ov0;
  logic [7:0] d0, od0;
  logic [15:0] sc0;
  logic       v1, r1, f1, c1, ir1, ov1;
  logic [7:0] d1, od1;
  logic [15:0] sc1;
  logic       v2, r2, f2, c2, ir2, ov2;
  logic [7:0] d2, od2;
  logic [1:0] sc2;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  pipe_stage_reg #(.DATA_W(8), .SKID(0), .CLEAR_ON_BUBBLE(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .in_data(d0),
    .out_valid(ov0), .out_ready(r0), .out_data(od0), .flush(f0), .stat_clr(c0), .stall_cnt(sc0));

  pipe_stage_reg #(.DATA_W(8), .SKID(1), .CLEAR_ON_BUBBLE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(r1), .out_data(od1), .flush(f1), .stat_clr(c1), .stall_cnt(sc1));

  pipe_stage_reg #(.DATA_W(8), .SKID(0), .CLEAR_ON_BUBBLE(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_data(d2),
    .out_valid(ov2), .out_ready(r2), .out_data(od2), .flush(f2), .stat_clr(c2), .stall_cnt(sc2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a transfer happens at the next edge whenever valid & ready hold mid-cycle.
  always @(negedge clk) begin
    if (rst && ov0 && r0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected: got %h, required no output", od0);
      end else begin
        chk("dut0_order", {24'h0, od0}, {24'h0, q0.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst && ov1 && r1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected: got %h, required no output", od1);
      end else begin
        chk("dut1_order", {24'h0, od1}, {24'h0, q1.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst && ov2 && r2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_unexpected: got %h, required no output", od2);
      end else begin
        chk("dut2_order", {24'h0, od2}, {24'h0, q2.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    {v0, r0, f0, c0, d0} = '0;
    {v1, r1, f1, c1, d1} = '0;
    {v2, r2, f2, c2, d2} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov0", ov0, 1'b0);
    chk("rst_ir0", ir0, 1'b1);
    chk("rst_ov1", ov1, 1'b0);
    chk("rst_ir1", ir1, 1'b1);
    chk("rst_od1", od1, 8'h00);
    chk("rst_sc1", sc1, 16'h0);
    rst = 1'b1;

    // No-skid streaming at full rate
    step();
    v0 = 1'b1; r0 = 1'b1; d0 = 8'h11; q0.push_back(8'h11);
    #1 chk("a_ir0", ir0, 1'b1);
    step();
    chk("a_lat_ov0", ov0, 1'b1);
    chk("a_lat_od0", od0, 8'h11);
    d0 = 8'h22; q0.push_back(8'h22);
    step();
    d0 = 8'h33; q0.push_back(8'h33);
    step();
    d0 = 8'h44; q0.push_back(8'h44);
    step();
    v0 = 1'b0;
    step();
    chk("a_ov0_idle", ov0, 1'b0);
    chk("a_od0_zero", od0, 8'h00);
    chk("a_sc0", sc0, 16'h0);
    chk("a_q0_empty", q0.size(), 0);

    // Skid: stall with A2 captured, A3 refused until drain
    v1 = 1'b1; r1 = 1'b1; d1 = 8'hA1; q1.push_back(8'hA1);
    #1 chk("b_ir1_empty", ir1, 1'b1);
    step();
    r1 = 1'b0; d1 = 8'hA2; q1.push_back(8'hA2);
    #1 chk("b_ir1_same_cycle", ir1, 1'b1);
    chk("b_od1_a1", od1, 8'hA1);
    step();
    d1 = 8'hA3;
    chk("b_ir1_full", ir1, 1'b0);
    chk("b_od1_hold1", od1, 8'hA1);
    step();
    chk("b_ir1_full2", ir1, 1'b0);
    chk("b_od1_hold2", od1, 8'hA1);
    step();
    chk("b_sc1_3", sc1, 16'd3);
    chk("b_od1_hold3", od1, 8'hA1);
    r1 = 1'b1;
    chk("b_ir1_still0", ir1, 1'b0);
    step();
    chk("b_ir1_reopen", ir1, 1'b1);
    chk("b_od1_a2", od1, 8'hA2);
    q1.push_back(8'hA3);
    step();
    v1 = 1'b0;
    step();
    chk("b_ov1_idle", ov1, 1'b0);
    chk("b_sc1_after", sc1, 16'd3);
    chk("b_q1_empty", q1.size(), 0);

    // Flush while FULL with a colliding input
    r1 = 1'b0; v1 = 1'b1; d1 = 8'hB1; q1.push_back(8'hB1);
    step();
    d1 = 8'hB2; q1.push_back(8'hB2);
    step();
    chk("c_ir1_full", ir1, 1'b0);
    d1 = 8'hFF; f1 = 1'b1;
    step();
    f1 = 1'b0; v1 = 1'b0;
    q1.delete();
    chk("c_ov1_flushed", ov1, 1'b0);
    chk("c_od1_zero", od1, 8'h00);
    chk("c_ir1_open", ir1, 1'b1);
    chk("c_sc1_kept", sc1, 16'd5);
    r1 = 1'b1; v1 = 1'b1; d1 = 8'hC3; q1.push_back(8'hC3);
    step();
    v1 = 1'b0;
    chk("c_od1_c3", od1, 8'hC3);
    step();
    chk("c_ov1_idle", ov1, 1'b0);

    // Stale output without bubble clearing
    v2 = 1'b1; r2 = 1'b1; d2 = 8'h5A; q2.push_back(8'h5A);
    step();
    v2 = 1'b0;
    chk("d_od2_5a", od2, 8'h5A);
    step();
    step();
    chk("d_ov2_idle", ov2, 1'b0);
    chk("d_od2_stale", od2, 8'h5A);

    // 2-bit counter saturation and clear priority
    v2 = 1'b1; r2 = 1'b0; d2 = 8'h3C; q2.push_back(8'h3C);
    step();
    v2 = 1'b0;
    chk("e_sc2_start", sc2, 2'd0);
    repeat (2) step();
    chk("e_sc2_2", sc2, 2'd2);
    repeat (4) step();
    chk("e_sc2_sat", sc2, 2'd3);
    chk("e_od2_stable", od2, 8'h3C);
    c2 = 1'b1;
    step();
    c2 = 1'b0;
    chk("e_sc2_clr", sc2, 2'd0);
    r2 = 1'b1;
    step();
    chk("e_ov2_drained", ov2, 1'b0);
    chk("e_q2_empty", q2.size(), 0);
    chk("e_q1_empty", q1.size(), 0);

    // Asynchronous reset while FULL
    r1 = 1'b0; v1 = 1'b1; d1 = 8'hD1; q1.push_back(8'hD1);
    step();
    d1 = 8'hD2; q1.push_back(8'hD2);
    step();
    v1 = 1'b0;
    chk("f_ov1_full", ov1, 1'b1);
    chk("f_sc1_pre", sc1, 16'd6);
    #2 rst = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    #1;
    chk("f_ov1_async", ov1, 1'b0);
    chk("f_sc1_async", sc1, 16'h0);
    chk("f_od1_async", od1, 8'h00);
    chk("f_ir1_async", ir1, 1'b1);
    step();
    rst = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
